// File: rtl/mc_pkg.sv
// Shared constants for the multi-cycle MIPS control unit: FSM state codes, opcode/funct
// values, ALU operation codes and datapath select encodings.
package mc_pkg;

  typedef logic [3:0] state_t;

  localparam state_t StFetch    = 4'd0;
  localparam state_t StDecode   = 4'd1;
  localparam state_t StMemAddr  = 4'd2;
  localparam state_t StMemRd    = 4'd3;
  localparam state_t StMemWb    = 4'd4;
  localparam state_t StMemWr    = 4'd5;
  localparam state_t StRExec    = 4'd6;
  localparam state_t StRWb      = 4'd7;
  localparam state_t StBranch   = 4'd8;
  localparam state_t StJump     = 4'd9;
`ifdef MC_ADDI_EN
  localparam state_t StAddiExec = 4'd10;
  localparam state_t StAddiWb   = 4'd11;
`endif

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;

  localparam logic [5:0] FnAdd = 6'h20;
  localparam logic [5:0] FnSub = 6'h22;
  localparam logic [5:0] FnAnd = 6'h24;
  localparam logic [5:0] FnOr  = 6'h25;
  localparam logic [5:0] FnNor = 6'h27;
  localparam logic [5:0] FnSlt = 6'h2A;

  localparam logic [3:0] AluAnd  = 4'b0000;
  localparam logic [3:0] AluOr   = 4'b0001;
  localparam logic [3:0] AluAdd  = 4'b0010;
  localparam logic [3:0] AluSub  = 4'b0110;
  localparam logic [3:0] AluSlt  = 4'b0111;
  localparam logic [3:0] AluNor  = 4'b1100;
  localparam logic [3:0] AluShl1 = 4'b1111;

  localparam logic [1:0] SrcBReg   = 2'b00;
  localparam logic [1:0] SrcBFour  = 2'b01;
  localparam logic [1:0] SrcBImm   = 2'b10;
  localparam logic [1:0] SrcBImmSh = 2'b11;

  localparam logic [1:0] PcAlu    = 2'b00;
  localparam logic [1:0] PcAluOut = 2'b01;
  localparam logic [1:0] PcJump   = 2'b10;

endpackage

// File: rtl/mc_alu_decode.sv
// R-type funct field to ALU operation decode; valid is low for unsupported funct codes.
module mc_alu_decode
  import mc_pkg::*;
(
  input  logic [5:0] funct,
  output logic [3:0] alu_op,
  output logic       valid
);

  always_comb begin
    alu_op = AluAdd;
    valid  = 1'b1;
    case (funct)
      FnAdd:   alu_op = AluAdd;
      FnSub:   alu_op = AluSub;
      FnAnd:   alu_op = AluAnd;
      FnOr:    alu_op = AluOr;
      FnNor:   alu_op = AluNor;
      FnSlt:   alu_op = AluSlt;
      default: valid  = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_control.sv
// Multi-cycle MIPS control FSM (Moore, except pc_write/ir_write gating).
// Define MC_ADDI_EN to support addi; otherwise opcode 0x08 decodes as illegal.
module mc_control
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zf,
  input  logic       mem_ready,
  output logic [3:0] alu_op,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_source,
  output logic       pc_write,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       illegal
);

  state_t     state_q, state_d;
  logic       illegal_q, illegal_d;
  logic [3:0] r_alu_op;
  logic       r_valid;

  mc_alu_decode u_alu_decode (
    .funct  (funct),
    .alu_op (r_alu_op),
    .valid  (r_valid)
  );

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    case (state_q)
      StFetch:  if (mem_ready) state_d = StDecode;
      StDecode: begin
        state_d = StFetch;
        case (opcode)
          OpLw, OpSw: state_d = StMemAddr;
          OpRtype: begin
            if (r_valid) state_d = StRExec;
            else         illegal_d = 1'b1;
          end
          OpBeq:      state_d = StBranch;
          OpJ:        state_d = StJump;
`ifdef MC_ADDI_EN
          OpAddi:     state_d = StAddiExec;
`endif
          default:    illegal_d = 1'b1;
        endcase
      end
      StMemAddr: state_d = (opcode == OpSw) ? StMemWr : StMemRd;
      StMemRd:   if (mem_ready) state_d = StMemWb;
      StMemWr:   if (mem_ready) state_d = StFetch;
      StRExec:   state_d = StRWb;
`ifdef MC_ADDI_EN
      StAddiExec: state_d = StAddiWb;
`endif
      default:   state_d = StFetch;
    endcase
  end

  // Reset overrides the state decode so nothing is written in the reset cycle.
  always_comb begin
    alu_op     = AluAdd;
    alu_src_a  = 1'b0;
    alu_src_b  = SrcBReg;
    pc_source  = PcAlu;
    pc_write   = 1'b0;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    if (!rst) begin
      case (state_q)
        StFetch: begin
          mem_read  = 1'b1;
          alu_src_b = SrcBFour;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        StDecode:  alu_src_b = SrcBImmSh;
        StMemAddr: begin
          alu_src_a = 1'b1;
          alu_src_b = SrcBImm;
        end
        StMemRd: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
        end
        StMemWb: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        StMemWr: begin
          mem_write = 1'b1;
          i_or_d    = 1'b1;
        end
        StRExec: begin
          alu_src_a = 1'b1;
          alu_op    = r_alu_op;
        end
        StRWb: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
        end
        StBranch: begin
          alu_src_a = 1'b1;
          alu_op    = AluSub;
          pc_source = PcAluOut;
          pc_write  = zf;
        end
        StJump: begin
          pc_source = PcJump;
          pc_write  = 1'b1;
        end
`ifdef MC_ADDI_EN
        StAddiExec: begin
          alu_src_a = 1'b1;
          alu_src_b = SrcBImm;
        end
        StAddiWb:  reg_write = 1'b1;
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StFetch;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  assign illegal = illegal_q;

endmodule

// File: tb/tb_mc_control.sv
// Directed bench for mc_control: expected output vectors are queued per cycle and compared
// at the falling edge. Honours MC_ADDI_EN the same way as the design.
module tb_mc_control;

  typedef struct packed {
    logic [3:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic       pc_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       illegal;
  } outs_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode, funct;
  logic       zf, mem_ready;
  logic [3:0] alu_op;
  logic       alu_src_a;
  logic [1:0] alu_src_b, pc_source;
  logic       pc_write, i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
  logic       illegal;

  int    checks = 0;
  int    errors = 0;
  logic  exp_ill = 1'b0;
  outs_t exp_q[$];
  string tag_q[$];

  mc_control dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .funct      (funct),
    .zf         (zf),
    .mem_ready  (mem_ready),
    .alu_op     (alu_op),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .pc_source  (pc_source),
    .pc_write   (pc_write),
    .i_or_d     (i_or_d),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .reg_write  (reg_write),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  // Expected outputs per state, written from the state table.
  function automatic outs_t e_base();
    outs_t o;
    o = '0;
    o.alu_op = 4'b0010;
    o.illegal = exp_ill;
    return o;
  endfunction

  function automatic outs_t e_fetch(input logic mr);
    outs_t o;
    o = e_base();
    o.mem_read = 1'b1;
    o.alu_src_b = 2'b01;
    o.ir_write = mr;
    o.pc_write = mr;
    return o;
  endfunction

  function automatic outs_t e_decode();
    outs_t o;
    o = e_base();
    o.alu_src_b = 2'b11;
    return o;
  endfunction

  function automatic outs_t e_imm_exec();
    outs_t o;
    o = e_base();
    o.alu_src_a = 1'b1;
    o.alu_src_b = 2'b10;
    return o;
  endfunction

  function automatic outs_t e_mem(input logic wr);
    outs_t o;
    o = e_base();
    o.i_or_d = 1'b1;
    o.mem_read = ~wr;
    o.mem_write = wr;
    return o;
  endfunction

  function automatic outs_t e_wb(input logic dst, input logic m2r);
    outs_t o;
    o = e_base();
    o.reg_write = 1'b1;
    o.reg_dst = dst;
    o.mem_to_reg = m2r;
    return o;
  endfunction

  function automatic outs_t e_rexec(input logic [3:0] op);
    outs_t o;
    o = e_base();
    o.alu_src_a = 1'b1;
    o.alu_op = op;
    return o;
  endfunction

  function automatic outs_t e_branch(input logic z);
    outs_t o;
    o = e_base();
    o.alu_src_a = 1'b1;
    o.alu_op = 4'b0110;
    o.pc_source = 2'b01;
    o.pc_write = z;
    return o;
  endfunction

  function automatic outs_t e_jump();
    outs_t o;
    o = e_base();
    o.pc_source = 2'b10;
    o.pc_write = 1'b1;
    return o;
  endfunction

  // One clock: drive inputs just after the rising edge, compare at the falling edge.
  task automatic cyc(input string tag, input logic r, input logic mr, input logic z,
                     input outs_t e);
    outs_t obs, exp;
    string t;
    rst = r;
    mem_ready = mr;
    zf = z;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(negedge clk);
    obs = {alu_op, alu_src_a, alu_src_b, pc_source, pc_write, i_or_d, mem_read, mem_write,
           ir_write, reg_dst, mem_to_reg, reg_write, illegal};
    exp = exp_q.pop_front();
    t = tag_q.pop_front();
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", t, obs, exp);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic instr(input logic [5:0] op, input logic [5:0] fn);
    opcode = op;
    funct = fn;
  endtask

  initial begin
    rst = 1'b1;
    mem_ready = 1'b1;
    zf = 1'b1;
    opcode = 6'h00;
    funct = 6'h22;
    repeat (2) @(posedge clk);
    #1;
    cyc("reset_forced", 1'b1, 1'b1, 1'b1, e_base());

    // R-type sub; zf and mem_ready toggled where they must be ignored
    instr(6'h00, 6'h22);
    cyc("sub_fetch",  1'b0, 1'b1, 1'b1, e_fetch(1'b1));
    cyc("sub_decode", 1'b0, 1'b0, 1'b1, e_decode());
    cyc("sub_exec",   1'b0, 1'b1, 1'b1, e_rexec(4'b0110));
    cyc("sub_wb",     1'b0, 1'b0, 1'b1, e_wb(1'b1, 1'b0));
    cyc("fetch_wait", 1'b0, 1'b0, 1'b0, e_fetch(1'b0));

    // R-type and
    instr(6'h00, 6'h24);
    cyc("and_fetch",  1'b0, 1'b1, 1'b0, e_fetch(1'b1));
    cyc("and_decode", 1'b0, 1'b1, 1'b0, e_decode());
    cyc("and_exec",   1'b0, 1'b0, 1'b0, e_rexec(4'b0000));
    cyc("and_wb",     1'b0, 1'b1, 1'b0, e_wb(1'b1, 1'b0));

    // lw with two wait states in MEM_RD
    instr(6'h23, 6'h00);
    cyc("lw_fetch",  1'b0, 1'b1, 1'b0, e_fetch(1'b1));
    cyc("lw_decode", 1'b0, 1'b1, 1'b0, e_decode());
    cyc("lw_addr",   1'b0, 1'b1, 1'b0, e_imm_exec());
    cyc("lw_rd_w1",  1'b0, 1'b0, 1'b0, e_mem(1'b0));
    cyc("lw_rd_w2",  1'b0, 1'b0, 1'b0, e_mem(1'b0));
    cyc("lw_rd",     1'b0, 1'b1, 1'b0, e_mem(1'b0));
    cyc("lw_wb",     1'b0, 1'b1, 1'b0, e_wb(1'b0, 1'b1));

    // beq taken, then not taken
    instr(6'h04, 6'h00);
    cyc("beq1_fetch",  1'b0, 1'b1, 1'b0, e_fetch(1'b1));
    cyc("beq1_decode", 1'b0, 1'b1, 1'b0, e_decode());
    cyc("beq1_br",     1'b0, 1'b0, 1'b1, e_branch(1'b1));
    cyc("beq0_fetch",  1'b0, 1'b1, 1'b1, e_fetch(1'b1));
    cyc("beq0_decode", 1'b0, 1'b1, 1'b1, e_decode());
    cyc("beq0_br",     1'b0, 1'b1, 1'b0, e_branch(1'b0));

    // j
    instr(6'h02, 6'h00);
    cyc("j_fetch",  1'b0, 1'b1, 1'b0, e_fetch(1'b1));
    cyc("j_decode", 1'b0, 1'b1, 1'b0, e_decode());
    cyc("j_jump",   1'b0, 1'b0, 1'b0, e_jump());

    // unsupported opcode sets the sticky flag
    instr(6'h3F, 6'h00);
    cyc("ill_fetch",  1'b0, 1'b1, 1'b0, e_fetch(1'b1));
    cyc("ill_decode", 1'b0, 1'b1, 1'b0, e_decode());
    exp_ill = 1'b1;
    cyc("ill_after",  1'b0, 1'b0, 1'b0, e_fetch(1'b0));

    // unsupported funct: no writes, flag stays set
    instr(6'h00, 6'h3F);
    cyc("badfn_fetch",  1'b0, 1'b1, 1'b0, e_fetch(1'b1));
    cyc("badfn_decode", 1'b0, 1'b1, 1'b0, e_decode());
    cyc("badfn_after",  1'b0, 1'b1, 1'b0, e_fetch(1'b1));

    // sw, reset while waiting in MEM_WR (state already in DECODE after last fetch)
    instr(6'h2B, 6'h00);
    cyc("sw_decode", 1'b0, 1'b1, 1'b0, e_decode());
    cyc("sw_addr",   1'b0, 1'b1, 1'b0, e_imm_exec());
    cyc("sw_wr_w1",  1'b0, 1'b0, 1'b0, e_mem(1'b1));
    cyc("sw_wr_w2",  1'b0, 1'b0, 1'b0, e_mem(1'b1));
    cyc("sw_rst",    1'b1, 1'b1, 1'b0, e_base());
    exp_ill = 1'b0;
    cyc("post_rst_fetch", 1'b0, 1'b0, 1'b0, e_fetch(1'b0));

    // addi
    instr(6'h08, 6'h00);
    cyc("addi_fetch",  1'b0, 1'b1, 1'b0, e_fetch(1'b1));
    cyc("addi_decode", 1'b0, 1'b1, 1'b0, e_decode());
`ifdef MC_ADDI_EN
    cyc("addi_exec",   1'b0, 1'b1, 1'b0, e_imm_exec());
    cyc("addi_wb",     1'b0, 1'b1, 1'b0, e_wb(1'b0, 1'b0));
`else
    exp_ill = 1'b1;
`endif
    cyc("addi_after",  1'b0, 1'b0, 1'b0, e_fetch(1'b0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
